sample_feeder: RTL and testbench

SAMPLE_FEEDER -- requirements
Module: sample_feeder

---
 rtl/sample_feeder.sv | 139 +++++++++++++
 tb/tb_sample_feeder.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/sample_feeder.sv
// -----------------------------------------------------------------------------
// sample_feeder
//   Buffers producer samples in a small FIFO and releases them at a fixed
//   sample rate (one pop attempt every DIV clocks while run=1), driving a
//   registered sample word plus a one-cycle shift-enable strobe for a FIR.
//
// Parameters
//   N      sample width in bits
//   DEPTH  FIFO depth in samples (power of two, >= 2)
//   DIV    sample period in clk cycles (>= 2)
//
// Ports
//   clk           clock, all state updates on rising edge
//   rst           asynchronous active-low reset
//   run           enables the sample-rate timer
//   in_valid      producer has in_data
//   in_data       incoming sample (N bits)
//   in_ready      FIFO can accept a sample (level != DEPTH)
//   clr_underrun  synchronous clear of the underrun flag
//   sample        registered sample driving the FIR input
//   ena           one-cycle strobe marking a new sample
//   level         current FIFO occupancy
//   underrun      sticky flag, set when a tick finds the FIFO empty
// -----------------------------------------------------------------------------
module sample_feeder #(
  parameter int N     = 16,
  parameter int DEPTH = 4,
  parameter int DIV   = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     run,
  input  logic                     in_valid,
  input  logic [N-1:0]             in_data,
  output logic                     in_ready,
  input  logic                     clr_underrun,
  output logic [N-1:0]             sample,
  output logic                     ena,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     underrun
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int TW = $clog2(DIV);

  localparam logic [TW-1:0] TIMER_MAX  = TW'(DIV - 1);
  localparam logic [LW-1:0] LEVEL_FULL = LW'(DEPTH);

  // State
  logic [N-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [LW-1:0] r_level;
  logic [TW-1:0] r_timer;
  logic [N-1:0]  r_sample;
  logic          r_ena;
  logic          r_underrun;

  // Per-cycle decisions
  logic          w_ready;
  logic          w_empty;
  logic          w_tick;
  logic          w_push;
  logic          w_pop;
  logic          w_underrun_evt;
  logic [LW-1:0] w_level_nxt;
  logic [TW-1:0] w_timer_nxt;

  // All handshake decisions use the registered level only, so a pushed sample
  // can never be popped in its own push cycle and in_ready never depends on
  // a same-cycle pop.
  always_comb begin
    w_ready        = (r_level != LEVEL_FULL);
    w_empty        = (r_level == '0);
    w_tick         = run && (r_timer == TIMER_MAX);
    w_push         = in_valid && w_ready;
    w_pop          = w_tick && !w_empty;
    w_underrun_evt = w_tick && w_empty;

    w_level_nxt = r_level;
    if (w_push && !w_pop) begin
      w_level_nxt = r_level + LW'(1);
    end else if (w_pop && !w_push) begin
      w_level_nxt = r_level - LW'(1);
    end

    w_timer_nxt = '0;
    if (run && (r_timer != TIMER_MAX)) begin
      w_timer_nxt = r_timer + TW'(1);
    end
  end

  // Control / datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_timer    <= '0;
      r_sample   <= '0;
      r_ena      <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      r_level <= w_level_nxt;
      r_timer <= w_timer_nxt;
      r_ena   <= w_pop;

      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
        r_sample <= r_mem[r_rd_ptr];
      end

      // A same-cycle underrun event wins over the clear.
      if (w_underrun_evt) begin
        r_underrun <= 1'b1;
      end else if (clr_underrun) begin
        r_underrun <= 1'b0;
      end
    end
  end

  // Storage is not reset: its contents are unobservable until written.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= in_data;
    end
  end

  assign in_ready = w_ready;
  assign sample   = r_sample;
  assign ena      = r_ena;
  assign level    = r_level;
  assign underrun = r_underrun;

endmodule

// File: tb/tb_sample_feeder.sv
// -----------------------------------------------------------------------------
// tb_sample_feeder
//   Self-checking bench for sample_feeder (N=16, DEPTH=4, DIV=8). A queue-based
//   reference model tracks the buffered samples, the sample clock phase and the
//   sticky underrun flag; every DUT output is compared after each clock.
// -----------------------------------------------------------------------------
module tb_sample_feeder;

  localparam int N     = 16;
  localparam int DEPTH = 4;
  localparam int DIV   = 8;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          run = 1'b0;
  logic          in_valid = 1'b0;
  logic [N-1:0]  in_data = '0;
  logic          clr_underrun = 1'b0;
  logic          in_ready;
  logic [N-1:0]  sample;
  logic          ena;
  logic [LW-1:0] level;
  logic          underrun;

  sample_feeder #(
    .N     (N),
    .DEPTH (DEPTH),
    .DIV   (DIV)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .run          (run),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .clr_underrun (clr_underrun),
    .sample       (sample),
    .ena          (ena),
    .level        (level),
    .underrun     (underrun)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  int q[$];
  int m_sample = 0;
  bit m_ena    = 1'b0;
  bit m_under  = 1'b0;
  int run_cnt  = 0;   // consecutive cycles run has been high so far

  // Capture of DUT output stream for ordering checks
  bit collect = 1'b0;
  int got[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string ctx);
    chk({ctx, ".sample"},   32'(sample),   32'(m_sample));
    chk({ctx, ".ena"},      32'(ena),      32'(m_ena));
    chk({ctx, ".level"},    32'(level),    32'(q.size()));
    chk({ctx, ".in_ready"}, 32'(in_ready), 32'(q.size() != DEPTH));
    chk({ctx, ".underrun"}, 32'(underrun), 32'(m_under));
  endtask

  task automatic m_reset();
    q.delete();
    m_sample = 0;
    m_ena    = 1'b0;
    m_under  = 1'b0;
    run_cnt  = 0;
  endtask

  // One clock: the model applies the same inputs the DUT sees at the edge,
  // then all outputs are compared 1 time unit later.
  task automatic step(input string ctx);
    bit tick, push, pop;
    int sz;
    @(posedge clk);
    sz   = q.size();
    tick = run && ((run_cnt % DIV) == DIV - 1);
    push = in_valid && (sz != DEPTH);
    pop  = tick && (sz > 0);
    m_ena = pop;
    if (pop) m_sample = q.pop_front();
    if (push) q.push_back(int'(in_data));
    if (tick && sz == 0) m_under = 1'b1;
    else if (clr_underrun) m_under = 1'b0;
    run_cnt = run ? run_cnt + 1 : 0;
    #1;
    if (collect && ena) got.push_back(int'(sample));
    check_all(ctx);
  endtask

  // Asynchronous reset pulse placed well away from any clock edge; outputs
  // are checked while rst is still low, before any clock can occur.
  task automatic do_reset(input string ctx);
    #2 rst = 1'b0;
    m_reset();
    #1 check_all(ctx);
    #2 rst = 1'b1;
  endtask

  initial begin
    int idx;
    bit acc;

    #11;
    do_reset("reset0");

    // Basic stream: three samples out at 8, 16, 24 cycles after run rises
    in_valid = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      in_data = N'(i);
      step("basic_push");
    end
    in_valid = 1'b0;
    run = 1'b1;
    for (int c = 1; c <= 26; c++) begin
      step("basic_run");
      if (c == 8 || c == 16 || c == 24) begin
        chk("basic_ena_at_tick", 32'(ena), 32'd1);
        chk("basic_sample_at_tick", 32'(sample), 32'(c / 8));
      end
    end
    chk("basic_level_drained", 32'(level), 32'd0);
    run = 1'b0;
    do_reset("reset1");

    // Full FIFO: fifth sample held by producer until the first pop
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_data = N'(16'h0010 + i);
      step("full_push");
    end
    chk("full_ready_low", 32'(in_ready), 32'd0);
    run = 1'b1;
    for (int c = 0; c < 10; c++) step("full_run");
    in_valid = 1'b0;
    for (int c = 0; c < 45; c++) step("full_drain");
    run = 1'b0;
    do_reset("reset2");

    // Underrun on an empty FIFO, then clear
    run = 1'b1;
    for (int c = 0; c < 8; c++) step("under_run");
    chk("under_flag_set", 32'(underrun), 32'd1);
    run = 1'b0;
    clr_underrun = 1'b1;
    step("under_clr");
    clr_underrun = 1'b0;
    chk("under_flag_clr", 32'(underrun), 32'd0);
    do_reset("reset3");

    // Simultaneous push and pop at level 2 on the tick cycle
    in_valid = 1'b1;
    in_data  = 16'h0B01; step("simul_fill");
    in_data  = 16'h0B02; step("simul_fill");
    in_valid = 1'b0;
    run = 1'b1;
    for (int c = 0; c < DIV - 1; c++) step("simul_wait");
    in_valid = 1'b1;
    in_data  = 16'h0B03;
    step("simul_tick");
    in_valid = 1'b0;
    chk("simul_level", 32'(level), 32'd2);
    chk("simul_head", 32'(sample), 32'h0B01);
    run = 1'b0;
    do_reset("reset4");

    // Reset mid-stream with level 3, then no ena and underrun after release
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = N'(16'h0C00 + i);
      step("mid_fill");
    end
    in_valid = 1'b0;
    do_reset("mid_reset");
    run = 1'b1;
    for (int c = 0; c < 20; c++) step("mid_after");
    chk("mid_underrun", 32'(underrun), 32'd1);
    run = 1'b0;
    do_reset("reset5");

    // Wrap-around: ten sequential values through the FIFO in order
    collect = 1'b1;
    got.delete();
    idx = 0;
    run = 1'b1;
    for (int c = 0; c < 200 && got.size() < 10; c++) begin
      in_valid = (idx < 10);
      in_data  = N'(16'h00A0 + idx);
      acc      = in_valid && in_ready;
      step("wrap");
      if (acc) idx++;
    end
    in_valid = 1'b0;
    collect = 1'b0;
    chk("wrap_count", 32'(got.size()), 32'd10);
    for (int k = 0; k < 10; k++) begin
      chk("wrap_order", (k < got.size()) ? 32'(got[k]) : 32'hFFFF_FFFF, 32'(16'h00A0 + k));
    end
    run = 1'b0;
    do_reset("reset6");

    // Randomized traffic against the model
    for (int c = 0; c < 400; c++) begin
      run          = ($urandom_range(0, 9) != 0);
      in_valid     = ($urandom_range(0, 2) == 0);
      in_data      = N'($urandom);
      clr_underrun = ($urandom_range(0, 15) == 0);
      step("rand");
    end
    run = 1'b0;
    in_valid = 1'b0;
    clr_underrun = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
